// File: rtl/sm4_ctr_pkg.sv
// Shared types and constants for the SM4 CTR-mode sequencer.
package sm4_ctr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEYWAIT,
    ST_ISSUE,
    ST_WAIT,
    ST_XOR,
    ST_OUT
  } state_e;

  typedef logic [127:0] block_t;

  localparam logic ENC_SEL = 1'b0;

endpackage

// File: rtl/sm4_ctr_inc.sv
// Counter-block increment: the low CtrW bits wrap, the upper bits never see a carry.
module sm4_ctr_inc
  import sm4_ctr_pkg::*;
#(
  parameter int CtrW = 32
) (
  input  logic [127:0] ctr,
  output logic [127:0] ctr_next
);

  localparam block_t Mask = (CtrW >= 128) ? '1 : ((block_t'(1) << CtrW) - block_t'(1));

  assign ctr_next = (ctr & ~Mask) | ((ctr + block_t'(1)) & Mask);

endmodule

// File: rtl/sm4_ctr_seq.sv
// CTR-mode job sequencer: feeds counter blocks to an SM4 core and XORs the keystream
// with a one-entry plaintext buffer.
//
// state   | meaning
// IDLE    | no job; start with a nonzero count launches one
// KEYWAIT | waiting for core key expansion
// ISSUE   | one-cycle request of the current counter block
// WAIT    | waiting for the keystream, bounded by the timeout timer
// XOR     | waiting for plaintext, then registering the ciphertext
// OUT     | ciphertext offered downstream
module sm4_ctr_seq
  import sm4_ctr_pkg::*;
#(
  parameter int CtrW       = 32,
  parameter int TimeoutCyc = 1024
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [127:0] iv_i,
  input  logic [15:0]  blk_cnt_i,
  input  logic         pt_valid_i,
  output logic         pt_ready_o,
  input  logic [127:0] pt_data_i,
  output logic         ct_valid_o,
  input  logic         ct_ready_i,
  output logic [127:0] ct_data_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic         core_valid_o,
  output logic [127:0] core_data_o,
  output logic         core_encdec_sel_o,
  input  logic         core_key_ready_i,
  input  logic         core_valid_i,
  input  logic [127:0] core_result_i
);

  localparam int TmrW = $clog2(TimeoutCyc + 1);

  state_e          state, state_next;
  block_t          ctr, ctr_inc, ks, pt_buf, ct_data;
  logic [15:0]     rem;
  logic [TmrW-1:0] tmr;
  logic            pt_full, done_q, err_q;
  logic            pt_hs, ct_hs, job_go, job_empty, timeout, last_blk;

  sm4_ctr_inc #(.CtrW(CtrW)) u_inc (
    .ctr      (ctr),
    .ctr_next (ctr_inc)
  );

  assign job_go    = (state == ST_IDLE) && start_i && (blk_cnt_i != '0);
  assign job_empty = (state == ST_IDLE) && start_i && (blk_cnt_i == '0);
  assign pt_ready_o = !pt_full && (state inside {ST_ISSUE, ST_WAIT, ST_XOR});
  assign pt_hs     = pt_valid_i && pt_ready_o;
  assign ct_valid_o = (state == ST_OUT);
  assign ct_hs     = ct_valid_o && ct_ready_i;
  assign last_blk  = (rem == 16'd1);
  assign timeout   = (state == ST_WAIT) && !core_valid_i && (tmr == TmrW'(1));

  always_comb begin
    state_next   = state;
    core_valid_o = 1'b0;
    unique case (state)
      ST_IDLE:    if (job_go) state_next = ST_KEYWAIT;
      ST_KEYWAIT: if (core_key_ready_i) state_next = ST_ISSUE;
      ST_ISSUE: begin
        core_valid_o = 1'b1;
        state_next   = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_valid_i) state_next = ST_XOR;
        else if (timeout) state_next = ST_IDLE;
      end
      ST_XOR:     if (pt_full) state_next = ST_OUT;
      ST_OUT:     if (ct_hs) state_next = last_blk ? ST_IDLE : ST_ISSUE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      ctr     <= '0;
      rem     <= '0;
      ks      <= '0;
      pt_buf  <= '0;
      pt_full <= 1'b0;
      ct_data <= '0;
      tmr     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= job_empty;
      if (job_go) begin
        ctr   <= iv_i;
        rem   <= blk_cnt_i;
        err_q <= 1'b0;
      end
      if (state == ST_ISSUE) tmr <= TmrW'(TimeoutCyc);
      else if (state == ST_WAIT) tmr <= tmr - TmrW'(1);
      if ((state == ST_WAIT) && core_valid_i) ks <= core_result_i;
      // An aborted job's buffered plaintext must not leak into the next job.
      if (timeout) begin
        err_q   <= 1'b1;
        pt_full <= 1'b0;
      end else if (pt_hs) begin
        pt_buf  <= pt_data_i;
        pt_full <= 1'b1;
      end else if ((state == ST_XOR) && pt_full) begin
        ct_data <= ks ^ pt_buf;
        pt_full <= 1'b0;
      end
      if (ct_hs) begin
        ctr <= ctr_inc;
        rem <= rem - 16'd1;
      end
    end
  end

  assign busy_o            = (state != ST_IDLE);
  assign done_o            = done_q || (ct_hs && last_blk);
  assign err_o             = err_q;
  assign ct_data_o         = ct_data;
  assign core_data_o       = ctr;
  assign core_encdec_sel_o = ENC_SEL;

endmodule

// File: tb/tb_sm4_ctr_seq.sv
// Randomised self-checking bench for sm4_ctr_seq with a transaction-level model and SM4 core stand-in.
module tb_sm4_ctr_seq;

  localparam int CTRW = 32;
  localparam int TO   = 64;
  localparam logic [127:0] KCONST = {4{32'hA5A5A5A5}};

  logic         clk = 1'b0;
  logic         rst_i, start_i, pt_valid_i, pt_ready_o, ct_valid_o, ct_ready_i;
  logic [127:0] iv_i, pt_data_i, ct_data_o, core_data_o, core_result_i;
  logic [15:0]  blk_cnt_i;
  logic         busy_o, done_o, err_o, core_valid_o, core_encdec_sel_o;
  logic         core_key_ready_i, core_valid_i;

  always #5 clk = ~clk;

  sm4_ctr_seq #(.CtrW(CTRW), .TimeoutCyc(TO)) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .start_i           (start_i),
    .iv_i              (iv_i),
    .blk_cnt_i         (blk_cnt_i),
    .pt_valid_i        (pt_valid_i),
    .pt_ready_o        (pt_ready_o),
    .pt_data_i         (pt_data_i),
    .ct_valid_o        (ct_valid_o),
    .ct_ready_i        (ct_ready_i),
    .ct_data_o         (ct_data_o),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .err_o             (err_o),
    .core_valid_o      (core_valid_o),
    .core_data_o       (core_data_o),
    .core_encdec_sel_o (core_encdec_sel_o),
    .core_key_ready_i  (core_key_ready_i),
    .core_valid_i      (core_valid_i),
    .core_result_i     (core_result_i)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [127:0] exp_core[$];
  logic [127:0] exp_ct[$];
  logic [127:0] pt_q[$];
  logic [127:0] seen_core[$];
  int job_left = 0;
  int core_pulses = 0;
  int done_total = 0;
  int first_core_cyc = -1;
  int first_ct_cyc = -1;
  logic [127:0] last_ct = '0;
  int core_lat = 5;
  int ready_mode = 2;
  int pt_mode = 2;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] ctr_at(logic [127:0] iv, int k);
    logic [127:0] r;
    r = iv;
    r[31:0] = iv[31:0] + 32'(k);
    return r;
  endfunction

  // SM4 core stand-in: E(x) = x ^ A5..A5 after core_lat cycles; core_lat 0 means no answer.
  int pend = 0;
  logic [127:0] pend_data = '0;
  initial begin
    core_valid_i  = 1'b0;
    core_result_i = '0;
    forever begin
      @(posedge clk); #1;
      core_valid_i = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          core_valid_i  = 1'b1;
          core_result_i = pend_data ^ KCONST;
        end
      end
      if (core_valid_o && core_lat > 0) begin
        pend      = core_lat;
        pend_data = core_data_o;
      end
    end
  end

  initial begin
    ct_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      ct_ready_i = (ready_mode == 2) ? 1'b1 : (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  initial begin
    logic hs;
    pt_valid_i = 1'b0;
    pt_data_i  = '0;
    forever begin
      @(negedge clk);
      hs = pt_valid_i && pt_ready_o && !rst_i;
      @(posedge clk); #1;
      if (hs && pt_q.size() > 0) void'(pt_q.pop_front());
      pt_valid_i = (pt_q.size() > 0) && ((pt_mode == 2) || ($urandom_range(0, 2) != 0));
      pt_data_i  = (pt_q.size() > 0) ? pt_q[0] : '0;
    end
  end

  // Compare process: every cycle, against the model queues.
  logic prev_cv = 1'b0, prev_ctv = 1'b0, prev_hs = 1'b0;
  logic [127:0] prev_ct = '0;
  always @(negedge clk) begin
    if (core_valid_o) begin
      core_pulses++;
      seen_core.push_back(core_data_o);
      check("core_valid_single_cycle", prev_cv, 1'b0);
      if (exp_core.size() == 0) check("core_request_expected", 1'b1, 1'b0);
      else check("core_data", core_data_o, exp_core.pop_front());
      if (first_core_cyc < 0) first_core_cyc = cyc;
    end
    if (ct_valid_o) begin
      if (first_ct_cyc < 0) first_ct_cyc = cyc;
      if (prev_ctv && !prev_hs) check("ct_data_stable", ct_data_o, prev_ct);
      if (ct_ready_i) begin
        last_ct = ct_data_o;
        if (exp_ct.size() == 0) check("ct_output_expected", 1'b1, 1'b0);
        else check("ct_data", ct_data_o, exp_ct.pop_front());
        check("done_with_last_block", done_o, job_left == 1);
        job_left--;
      end
    end
    check("encdec_sel", core_encdec_sel_o, 1'b0);
    if (done_o) done_total++;
    prev_cv  = core_valid_o;
    prev_ctv = ct_valid_o;
    prev_hs  = ct_valid_o && ct_ready_i;
    prev_ct  = ct_data_o;
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic start_job(logic [127:0] iv, int n, int lat, bit zero_pt);
    logic [127:0] pt;
    core_lat = lat;
    for (int k = 0; k < n; k++) begin
      pt = zero_pt ? '0 : {$urandom(), $urandom(), $urandom(), $urandom()};
      exp_core.push_back(ctr_at(iv, k));
      pt_q.push_back(pt);
      exp_ct.push_back(ctr_at(iv, k) ^ KCONST ^ pt);
    end
    job_left  = n;
    iv_i      = iv;
    blk_cnt_i = 16'(n);
    start_i   = 1'b1;
    tick();
    start_i   = 1'b0;
    iv_i      = {$urandom(), $urandom(), $urandom(), $urandom()};
    blk_cnt_i = 16'($urandom_range(0, 65535));
  endtask

  task automatic wait_done(int budget, int d0, string name);
    int t = 0;
    while (done_total == d0 && t < budget) begin
      tick();
      t++;
    end
    check({name, "_done_within_budget"}, done_total != d0, 1'b1);
    check({name, "_ct_drained"}, exp_ct.size(), 0);
    check({name, "_core_drained"}, exp_core.size(), 0);
  endtask

  task automatic check_zero(string tag);
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_done"}, done_o, 1'b0);
    check({tag, "_err"}, err_o, 1'b0);
    check({tag, "_core_valid"}, core_valid_o, 1'b0);
    check({tag, "_ct_valid"}, ct_valid_o, 1'b0);
    check({tag, "_pt_ready"}, pt_ready_o, 1'b0);
    check({tag, "_core_data"}, core_data_o, '0);
    check({tag, "_ct_data"}, ct_data_o, '0);
  endtask

  task automatic flush_model();
    exp_core.delete();
    exp_ct.delete();
    pt_q.delete();
    job_left = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, p0, d0, t;
    logic [127:0] held, iv;
    rst_i = 1'b1; start_i = 1'b0; iv_i = '0; blk_cnt_i = '0; core_key_ready_i = 1'b1;
    tick(3);
    check_zero("reset");
    rst_i = 1'b0;
    tick(2);

    // Single block, latency and literal ciphertext.
    first_core_cyc = -1; first_ct_cyc = -1;
    p0 = core_pulses; d0 = done_total; s = cyc;
    start_job(128'h1, 1, 5, 1'b1);
    wait_done(100, d0, "single");
    check("latency_core_valid", first_core_cyc - s, 2);
    check("latency_ct_valid", first_ct_cyc - s, 9);
    check("single_ct_literal", last_ct, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A4);
    tick(3);
    check("single_core_pulses", core_pulses - p0, 1);
    check("single_done_once", done_total - d0, 1);

    // Counter wrap of the low 32 bits.
    seen_core.delete();
    ready_mode = 1; d0 = done_total;
    start_job({32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C, 32'hFFFFFFFF}, 2, 3, 1'b0);
    wait_done(200, d0, "wrap");
    check("wrap_seen_two", seen_core.size(), 2);
    if (seen_core.size() == 2)
      check("wrap_second_block", seen_core[1], {32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C, 32'h00000000});

    // Back-pressure: no new request until the held ciphertext is taken.
    ready_mode = 0; p0 = core_pulses; d0 = done_total;
    start_job({$urandom(), $urandom(), $urandom(), $urandom()}, 2, 2, 1'b0);
    t = 0;
    while (!ct_valid_o && t < 100) begin tick(); t++; end
    check("bp_ct_valid_seen", ct_valid_o, 1'b1);
    held = ct_data_o;
    tick(10);
    check("bp_ct_held", ct_data_o, held);
    check("bp_no_second_request", core_pulses - p0, 1);
    ready_mode = 2;
    wait_done(200, d0, "bp");
    check("bp_two_requests", core_pulses - p0, 2);

    // Timeout: core never answers.
    first_core_cyc = -1; d0 = done_total;
    start_job({$urandom(), $urandom(), $urandom(), $urandom()}, 3, 0, 1'b0);
    t = 0;
    while (!err_o && t < TO + 40) begin tick(); t++; end
    check("timeout_err_set", err_o, 1'b1);
    check("timeout_cycle", cyc - first_core_cyc, TO + 1);
    check("timeout_not_busy", busy_o, 1'b0);
    check("timeout_no_done", done_total - d0, 0);
    flush_model();
    tick(2);
    check("timeout_err_sticky", err_o, 1'b1);
    d0 = done_total;
    start_job({$urandom(), $urandom(), $urandom(), $urandom()}, 1, 4, 1'b0);
    check("restart_clears_err", err_o, 1'b0);
    wait_done(100, d0, "after_timeout");

    // Zero-length job.
    p0 = core_pulses; d0 = done_total;
    blk_cnt_i = '0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("zero_done_next", done_o, 1'b1);
    check("zero_not_busy", busy_o, 1'b0);
    tick();
    check("zero_done_pulse", done_o, 1'b0);
    tick(5);
    check("zero_no_request", core_pulses - p0, 0);
    check("zero_done_once", done_total - d0, 1);

    // Start while busy is ignored.
    d0 = done_total;
    start_job({$urandom(), $urandom(), $urandom(), 32'hFFFFFFFE}, 3, 4, 1'b0);
    tick(6);
    iv_i = {4{$urandom()}}; blk_cnt_i = 16'd5; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_done(300, d0, "busy_start");
    tick(10);
    check("busy_start_idle", busy_o, 1'b0);
    check("busy_start_one_done", done_total - d0, 1);

    // Reset mid-job, late core answer must be ignored.
    p0 = core_pulses; d0 = done_total;
    start_job({$urandom(), $urandom(), $urandom(), $urandom()}, 4, 20, 1'b0);
    t = 0;
    while (!core_valid_o && t < 20) begin tick(); t++; end
    tick(3);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_zero("midreset");
    flush_model();
    p0 = core_pulses;
    tick(25);
    check("midreset_idle", busy_o, 1'b0);
    check("midreset_no_ct", ct_valid_o, 1'b0);
    check("midreset_no_request", core_pulses - p0, 0);
    check("midreset_no_done", done_total - d0, 0);

    // Randomised jobs.
    ready_mode = 1; pt_mode = 1;
    for (int j = 0; j < 10; j++) begin
      iv = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (j % 3 == 0) iv[31:0] = 32'hFFFFFFFF - 32'($urandom_range(0, 2));
      d0 = done_total;
      core_key_ready_i = (j % 2 == 0);
      start_job(iv, $urandom_range(1, 5), $urandom_range(1, 6), 1'b0);
      if (j % 2 != 0) begin
        tick($urandom_range(1, 5));
        core_key_ready_i = 1'b1;
      end
      wait_done(2000, d0, "random");
    end

    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sm4_ctr_seq.md
SM4_CTR_SEQ -- requirements
Module: sm4_ctr_seq

Interface
REQ-001 SHALL have parameter CtrW, default 32, the number of low counter bits incremented per block (1..128).
REQ-002 SHALL have parameter TimeoutCyc, default 1024, the maximum number of cycles spent waiting for the core result.
REQ-003 SHALL have the ports below; clock and reset come first.
- clk_i  in  1  sole clock.
- rst_i  in  1  reset; synchronous, active-high.
- start_i  in  1  one-cycle pulse that starts a job.
- iv_i  in  128  initial counter block; sampled at start.
- blk_cnt_i  in  16  number of blocks in the job; sampled at start.
- pt_valid_i / pt_ready_o  in/out  1  plaintext handshake.
- pt_data_i  in  128  plaintext block.
- ct_valid_o / ct_ready_i  out/in  1  ciphertext handshake.
- ct_data_o  out  128  ciphertext block.
- busy_o  out  1  a job is active.
- done_o  out  1  one-cycle pulse when a job completes.
- err_o  out  1  sticky timeout flag.
- core_valid_o  out  1  one-cycle request to the SM4 core.
- core_data_o  out  128  counter block sent to the core.
- core_encdec_sel_o  out  1  constant 0 (encrypt).
- core_key_ready_i  in  1  core key expansion is complete.
- core_valid_i  in  1  core result-valid pulse.
- core_result_i  in  128  keystream block from the core.

Function
REQ-004 SHALL implement an FSM with states IDLE, KEYWAIT, ISSUE, WAIT, XOR and OUT.
REQ-005 IDLE: start_i with blk_cnt_i != 0 SHALL latch ctr=iv_i and rem=blk_cnt_i, clear err_o, and go to KEYWAIT.
REQ-006 IDLE: start_i with blk_cnt_i == 0 SHALL pulse done_o the next cycle, issue no core request, and stay in IDLE.
REQ-007 start_i outside IDLE SHALL be ignored.
REQ-008 KEYWAIT SHALL go to ISSUE on the first cycle in which core_key_ready_i=1.
REQ-009 ISSUE SHALL last exactly one cycle, with core_valid_o=1 and core_data_o=ctr, then go to WAIT.
REQ-010 core_valid_o SHALL be 0 in every state other than ISSUE.
REQ-011 core_data_o SHALL hold ctr in all states.
REQ-012 WAIT: core_valid_i=1 SHALL capture core_result_i into the keystream register ks and go to XOR.
REQ-013 core_valid_i outside WAIT SHALL be ignored.
REQ-014 WAIT: if TimeoutCyc cycles pass without core_valid_i, the block SHALL set err_o, go to IDLE and NOT pulse done_o.
REQ-015 The plaintext buffer SHALL have one entry.
REQ-016 pt_ready_o SHALL be 1 only when the buffer is empty and the state is ISSUE, WAIT or XOR; a handshake fills the buffer.
REQ-017 XOR with the buffer full SHALL register ct_data_o = ks XOR pt_buf, empty the buffer, and go to OUT.
REQ-018 ct_valid_o SHALL be asserted the cycle after REQ-017 and be 1 only in OUT.
REQ-019 ct_data_o SHALL remain stable while ct_valid_o=1 and ct_ready_i=0.
REQ-020 OUT handshake SHALL do the following:
- increment ctr[CtrW-1:0] modulo 2^CtrW, leaving ctr[127:CtrW] unchanged (no carry out; all-ones wraps to 0);
- decrement rem;
- if rem was 1, go to IDLE and pulse done_o in the same cycle as the handshake; otherwise go to ISSUE.
REQ-021 busy_o SHALL be 1 in every state except IDLE.
REQ-022 Minimum latency, with key ready and the core answering in N cycles: start@0 -> core_valid_o@2 -> core_valid_i@2+N -> ct_valid_o@4+N, provided plaintext was already buffered.

Reset
REQ-023 rst_i=1 at a clock edge SHALL force the following, including mid-job, and discard any in-flight core result:
- FSM to IDLE;
- ctr, rem, ks, pt_buf and ct_data_o to 0;
- buffer empty;
- pt_ready_o, ct_valid_o, busy_o, done_o, err_o, core_valid_o and core_data_o to 0.
REQ-024 Reset SHALL have no asynchronous path.

Structure
REQ-025 A shared package sm4_ctr_pkg SHALL define the FSM state enum, the 128-bit block typedef, and the constant for encrypt select = 0.
REQ-026 The counter increment (masked CtrW-bit add) SHALL be the sub-module sm4_ctr_inc.
REQ-027 All other logic SHALL be in sm4_ctr_seq.
REQ-028 The block SHALL connect directly to the SM4 core's valid_in, data_in, encdec_sel_in, key_exp_ready_out, valid_out and result_out.

Verification
REQ-029 Single block: key ready; iv=0x0…01; pt=0; core model returns E(x)=x XOR 0xA5…A5 after 5 cycles -> ct=0xA5…A4, done_o pulses once, core_valid_o high exactly 1 cycle.
REQ-030 Wrap: CtrW=32, iv low word=0xFFFFFFFF, blk_cnt=2 -> second core_data_o low word=0x00000000 and upper 96 bits unchanged.
REQ-031 Back-pressure: ct_ready_i held 0 for 10 cycles -> ct_data_o stable, no second core_valid_o until the handshake.
REQ-032 Timeout: core never answers -> err_o=1 at TimeoutCyc after entering WAIT, busy_o=0, no done_o; next start clears err_o.
REQ-033 blk_cnt=0 -> done_o the next cycle, core_valid_o never asserted. start_i during busy -> ignored.
REQ-034 Reset mid-job (in WAIT, blk_cnt=4) -> all outputs 0 next cycle; a late core_valid_i is ignored.
